// File: rtl/gray_threshold.sv
// Purpose : copy a BMP header from ROM to RAM, then binarize each pixel on its B byte against a latched threshold.
// Latency : start accepted in cycle 0 -> last RAM write in cycle 2*BMP_TOTAL_SIZE, done pulse in the cycle after.
// Backpres: none; ROM data is used in the same cycle it is addressed and RAM accepts every write. Optional macro THRESH_INVERT_EN flips result polarity.
module gray_threshold #(
    parameter int BYTE_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 20,
    parameter int BMP_HEADER_SIZE = 54,
    parameter int BMP_TOTAL_SIZE  = 54 + 3 * 512 * 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [BYTE_WIDTH-1:0] threshold,
    input  logic [BYTE_WIDTH-1:0] ROM_Q,
    output logic                  ROM_valid,
    output logic [ADDR_WIDTH-1:0] ROM_addr,
    output logic                  RAM_valid,
    output logic [BYTE_WIDTH-1:0] RAM_D,
    output logic [ADDR_WIDTH-1:0] RAM_addr,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_HDR = 3'd1,
        WR_HDR = 3'd2,
        RD_PIX = 3'd3,
        WR_PIX = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] HDR_LAST  = ADDR_WIDTH'(BMP_HEADER_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] TOTAL     = ADDR_WIDTH'(BMP_TOTAL_SIZE);
    localparam logic [BYTE_WIDTH-1:0] ALL_ONES  = {BYTE_WIDTH{1'b1}};
    localparam logic [BYTE_WIDTH-1:0] ALL_ZEROS = '0;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [1:0]              cnt_q, cnt_d;       // byte index inside a pixel triplet
    logic [BYTE_WIDTH-1:0]   data_q, data_d;     // header byte or pixel B byte
    logic [BYTE_WIDTH-1:0]   thr_q, thr_d;
    logic                    pix_hit;
    logic [BYTE_WIDTH-1:0]   pix_res;

    // Binarization result for the latched B byte against the threshold captured at start
    always_comb begin
        pix_hit = (data_q >= thr_q);
`ifdef THRESH_INVERT_EN
        pix_res = pix_hit ? ALL_ZEROS : ALL_ONES;
`else
        pix_res = pix_hit ? ALL_ONES : ALL_ZEROS;
`endif
    end

    // Next-state, datapath updates and strobes
    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        ram_addr_d = ram_addr_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        thr_d      = thr_q;
        ROM_valid  = 1'b0;
        RAM_valid  = 1'b0;
        RAM_D      = data_q;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    thr_d   = threshold;
                    state_d = RD_HDR;
                end
            end
            RD_HDR: begin
                ROM_valid  = 1'b1;
                data_d     = ROM_Q;
                rom_addr_d = rom_addr_q + 1'b1;
                state_d    = WR_HDR;
            end
            WR_HDR: begin
                RAM_valid  = 1'b1;
                ram_addr_d = ram_addr_q + 1'b1;
                state_d    = (ram_addr_q == HDR_LAST) ? RD_PIX : RD_HDR;
            end
            RD_PIX: begin
                ROM_valid  = 1'b1;
                rom_addr_d = rom_addr_q + 1'b1;
                // Only B drives the decision; G and R are read to keep ROM_addr in step
                if (cnt_q == 2'd0) data_d = ROM_Q;
                if (cnt_q == 2'd2) begin
                    cnt_d   = 2'd0;
                    state_d = WR_PIX;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            WR_PIX: begin
                RAM_valid  = 1'b1;
                RAM_D      = pix_res;
                ram_addr_d = ram_addr_q + 1'b1;
                if (cnt_q == 2'd2) begin
                    cnt_d   = 2'd0;
                    state_d = (ram_addr_d < TOTAL) ? RD_PIX : DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                done       = 1'b1;
                rom_addr_d = '0;
                ram_addr_d = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any run in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rom_addr_q <= '0;
            ram_addr_q <= '0;
            cnt_q      <= 2'd0;
            data_q     <= '0;
            thr_q      <= '0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            ram_addr_q <= ram_addr_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            thr_q      <= thr_d;
        end
    end

    assign ROM_addr = rom_addr_q;
    assign RAM_addr = ram_addr_q;

endmodule

// File: tb/tb_gray_threshold.sv
module tb_gray_threshold;

    localparam int HDR   = 54;
    localparam int TOT   = 66;
    localparam int NPIX  = (TOT - HDR) / 3;
    localparam int DONE_CYC = 2 * TOT + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  threshold = 8'd0;
    logic [7:0]  ROM_Q;
    logic        ROM_valid;
    logic [19:0] ROM_addr;
    logic        RAM_valid;
    logic [7:0]  RAM_D;
    logic [19:0] RAM_addr;
    logic        done;

    logic [7:0]  rom [0:127];
    logic [7:0]  ram [0:127];
    logic        wr  [0:127];
    logic        ram_clr = 1'b0;
    int          wcnt;

    int n_cmp = 0;
    int n_bad = 0;

    gray_threshold #(
        .BYTE_WIDTH(8), .ADDR_WIDTH(20), .BMP_HEADER_SIZE(HDR), .BMP_TOTAL_SIZE(TOT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .threshold(threshold),
        .ROM_Q(ROM_Q), .ROM_valid(ROM_valid), .ROM_addr(ROM_addr),
        .RAM_valid(RAM_valid), .RAM_D(RAM_D), .RAM_addr(RAM_addr), .done(done)
    );

    always #5 clk = ~clk;

    assign ROM_Q = (ROM_addr < 20'd128) ? rom[ROM_addr[6:0]] : 8'h00;

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 128; i++) begin
                ram[i] <= 8'h00;
                wr[i]  <= 1'b0;
            end
            wcnt <= 0;
        end else if (RAM_valid) begin
            ram[RAM_addr[6:0]] <= RAM_D;
            wr[RAM_addr[6:0]]  <= 1'b1;
            wcnt <= wcnt + 1;
        end
    end

    // Expected file byte: header copied, every pixel byte is the binarized B value
    function automatic logic [7:0] exp_byte(input int a, input logic [7:0] thr);
        int   p;
        logic hit;
        if (a < HDR) return rom[a];
        p   = (a - HDR) / 3;
        hit = (rom[HDR + 3 * p] >= thr);
`ifdef THRESH_INVERT_EN
        return hit ? 8'd0 : 8'd255;
`else
        return hit ? 8'd255 : 8'd0;
`endif
    endfunction

    task automatic clear_ram();
        @(negedge clk); ram_clr = 1'b1;
        @(negedge clk); ram_clr = 1'b0;
    endtask

    task automatic load_rom(input logic [7:0] b0, b1, b2, b3, input bit rnd);
        logic [7:0] bs [0:3];
        bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
        for (int i = 0; i < 128; i++) rom[i] = rnd ? 8'($urandom) : 8'(i);
        for (int p = 0; p < NPIX; p++) rom[HDR + 3 * p] = bs[p];
    endtask

    task automatic check_ram(input logic [7:0] thr, input string name);
        logic [7:0] e;
        for (int a = 0; a < TOT; a++) begin
            e = exp_byte(a, thr);
            n_cmp++;
            if (wr[a] !== 1'b1 || ram[a] !== e) begin
                n_bad++;
                $display("FAIL %s byte %0d: got %h (written=%0b) expected %h", name, a, ram[a], wr[a], e);
            end
        end
        n_cmp++;
        if (wcnt !== TOT) begin
            n_bad++;
            $display("FAIL %s write count: got %0d expected %0d", name, wcnt, TOT);
        end
    endtask

    // Start a run at cycle 0, scramble the threshold input mid-run, check done timing and strobe exclusion
    task automatic do_run(input logic [7:0] thr, input string name);
        int cyc;
        int overlap;
        clear_ram();
        n_cmp++;
        if (ROM_addr !== 20'd0 || RAM_addr !== 20'd0) begin
            n_bad++;
            $display("FAIL %s start addr: got rom=%0d ram=%0d expected 0/0", name, ROM_addr, RAM_addr);
        end
        threshold = thr;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        cyc       = 1;
        overlap   = 0;
        while (done !== 1'b1 && cyc < 400) begin
            if (ROM_valid && RAM_valid) overlap++;
            threshold = 8'($urandom);
            in_valid  = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        if (ROM_valid && RAM_valid) overlap++;
        n_cmp++;
        if (done !== 1'b1 || cyc !== DONE_CYC) begin
            n_bad++;
            $display("FAIL %s done cycle: got %0d (done=%b) expected %0d", name, cyc, done, DONE_CYC);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s done width: done still %b one cycle later, expected 0", name, done);
        end
        n_cmp++;
        if (overlap !== 0) begin
            n_bad++;
            $display("FAIL %s strobe overlap: got %0d cycles expected 0", name, overlap);
        end
        check_ram(thr, name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({ROM_valid, RAM_valid, done} !== 3'b000 || ROM_addr !== 20'd0 ||
            RAM_addr !== 20'd0 || RAM_D !== 8'd0) begin
            n_bad++;
            $display("FAIL reset outputs: got rv=%b wv=%b d=%b ra=%0d wa=%0d D=%h expected all 0",
                     ROM_valid, RAM_valid, done, ROM_addr, RAM_addr, RAM_D);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        load_rom(8'd10, 8'd128, 8'd127, 8'd255, 1'b0);
        do_run(8'd128, "basic");
    endtask

    task automatic test_boundary();
        load_rom(8'd10, 8'd128, 8'd127, 8'd255, 1'b0);
        do_run(8'd0,   "thr0");
        do_run(8'd255, "thr255");
    endtask

    task automatic test_random();
        logic [7:0] t;
        for (int r = 0; r < 4; r++) begin
            load_rom(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
            t = (r % 2 == 0) ? rom[HDR + 3 * $urandom_range(0, NPIX - 1)] : 8'($urandom);
            do_run(t, "random");
        end
    endtask

    task automatic test_midrun_reset();
        int idle_wr;
        load_rom(8'd10, 8'd128, 8'd127, 8'd255, 1'b0);
        threshold = 8'd128;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        for (int c = 1; c < 70; c++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (RAM_valid !== 1'b0 || ROM_addr !== 20'd0 || RAM_addr !== 20'd0) begin
            n_bad++;
            $display("FAIL midrun reset abort: got wv=%b ra=%0d wa=%0d expected 0/0/0", RAM_valid, ROM_addr, RAM_addr);
        end
        @(negedge clk); rst_n = 1'b1;
        idle_wr = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (RAM_valid || ROM_valid) idle_wr++;
        end
        n_cmp++;
        if (idle_wr !== 0) begin
            n_bad++;
            $display("FAIL midrun reset idle: got %0d strobe cycles expected 0", idle_wr);
        end
        do_run(8'd128, "restart");
    endtask

    task automatic test_back_to_back();
        load_rom(8'd200, 8'd3, 8'd99, 8'd100, 1'b1);
        do_run(8'd100, "b2b_a");
        do_run(8'd4,   "b2b_b");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_random();
        test_midrun_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gray_threshold.md
GRAY_THRESHOLD -- requirements
Module: gray_threshold

Interface
REQ-001 Parameter BYTE_WIDTH, default 8, SHALL set the data byte width.
REQ-002 Parameter ADDR_WIDTH, default 20, SHALL set the ROM/RAM address width.
REQ-003 Parameter BMP_HEADER_SIZE, default 54, SHALL set the header byte count, which is copied unchanged.
REQ-004 Parameter BMP_TOTAL_SIZE, default 54+3*512*512, SHALL set the total file bytes; (BMP_TOTAL_SIZE-BMP_HEADER_SIZE) SHALL be a multiple of 3.
REQ-005 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  start request, sampled only in IDLE.
REQ-008 threshold  input  BYTE_WIDTH  binarization level, captured when the start is accepted.
REQ-009 ROM_Q  input  BYTE_WIDTH  byte at ROM_addr, combinationally valid in the same cycle.
REQ-010 ROM_valid  output  1  read strobe.
REQ-011 ROM_addr  output  ADDR_WIDTH  read address.
REQ-012 RAM_valid  output  1  write strobe; RAM writes RAM_D to RAM_addr on the edge ending the cycle.
REQ-013 RAM_D  output  BYTE_WIDTH  write data.
REQ-014 RAM_addr  output  ADDR_WIDTH  write address.
REQ-015 done  output  1  one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have six states: IDLE, RD_HDR, WR_HDR, RD_PIX, WR_PIX and DONE.
REQ-017 IDLE->RD_HDR SHALL occur when in_valid=1; in_valid SHALL be ignored in every other state.
REQ-018 Header copy: RD_HDR (1 cycle, ROM_valid=1, ROM_Q latched) SHALL be followed by WR_HDR (1 cycle, RAM_valid=1, RAM_D=latched byte), repeated BMP_HEADER_SIZE times, then the FSM SHALL go to RD_PIX.
REQ-019 RD_PIX SHALL last 3 cycles with ROM_valid=1 and SHALL latch byte 0 (B) of the triplet; bytes 1 and 2 SHALL be read and discarded.
REQ-020 WR_PIX SHALL last 3 cycles with RAM_valid=1 and SHALL write the same result byte 3 times (B, G, R).
REQ-021 After WR_PIX the FSM SHALL go to RD_PIX if RAM_addr<BMP_TOTAL_SIZE, else to DONE.
REQ-022 Result byte SHALL be all-ones (255) if B>=threshold, else 0, using an unsigned compare.
REQ-023 ROM_addr SHALL increment by 1 after each cycle with ROM_valid=1; RAM_addr SHALL increment by 1 after each cycle with RAM_valid=1.
REQ-024 ROM_valid and RAM_valid SHALL never be high in the same cycle.
REQ-025 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-026 On entry to IDLE from DONE, both addresses SHALL be cleared to 0, allowing a rerun.
REQ-027 Latency: with in_valid accepted in cycle 0, the last RAM write SHALL occur in cycle 2*BMP_TOTAL_SIZE and done SHALL occur in cycle 2*BMP_TOTAL_SIZE+1.
REQ-028 Boundary values: threshold=0 SHALL yield all pixels 255; threshold=255 SHALL yield 255 only where B=255.
REQ-029 Threshold changes mid-run SHALL have no effect until the next start.

Reset
REQ-030 While rst_n=0, outputs SHALL be: state=IDLE, ROM_valid=0, RAM_valid=0, done=0, ROM_addr=0, RAM_addr=0, RAM_D=0; the latched threshold and pixel registers SHALL be 0.
REQ-031 Reset asserted mid-run SHALL abort immediately with no further writes; the first in_valid after release SHALL restart from address 0.

Configuration
REQ-032 Macro THRESH_INVERT_EN: when defined, the result byte SHALL be 0 if B>=threshold, else 255; when undefined, REQ-022 polarity SHALL apply; timing SHALL be identical in both builds.

Verification (BMP_HEADER_SIZE=54, BMP_TOTAL_SIZE=66, 4 pixels)
REQ-033 Header bytes 0..53 = address value, pixels B=10,128,127,255, threshold=128 -> RAM[0..53] equals ROM[0..53]; pixel bytes = 0,0,0 / 255,255,255 / 0,0,0 / 255,255,255.
REQ-034 in_valid at cycle 0 -> done=1 exactly in cycle 133, one cycle wide; ROM_valid and RAM_valid are never high together.
REQ-035 threshold=0, then a second run with threshold=255 -> run 1 writes all pixels 255; run 2 writes 255 only for pixel 4; second run addresses start at 0.
REQ-036 rst_n pulsed low in cycle 70 -> no RAM_valid until a new in_valid; the restarted run completes correctly.
REQ-037 THRESH_INVERT_EN defined, stimulus as REQ-033 -> pixel bytes inverted (255/0/255/0) with the same done cycle.
